// File: rtl/tpu_ctrl_pkg.sv
// Shared types and constants for the TPU multiply controller:
// FSM state encoding, host address regions and multiply length.
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        MULTIPLY = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Host address regions, selected by req_addr[15:8]
    localparam logic [7:0] REG_A     = 8'h01;
    localparam logic [7:0] REG_B     = 8'h02;
    localparam logic [7:0] REG_C     = 8'h03;
    localparam logic [7:0] REG_START = 8'h04;

    // Cycles needed to stream A/B through a DIM x DIM systolic array
    function automatic int mul_cycles(input int dim);
        return 3 * dim - 2;
    endfunction

endpackage

// File: rtl/tpu_addr_decode.sv
// Combinational host address decoder: maps a request address and
// direction to a region, a row select, the C half select, a START
// flag and an error flag for unmapped or illegal accesses.
module tpu_addr_decode
    import tpu_ctrl_pkg::*;
#(
    parameter int DIM   = 8,
    parameter int ADDRW = 16,
    parameter int ROWW  = 3
) (
    input  logic             we_i,
    input  logic [ADDRW-1:0] addr_i,
    output logic [7:0]       region_o,
    output logic [ROWW-1:0]  row_o,
    output logic             c_half_o,
    output logic             start_o,
    output logic             err_o
);

    // A rows are 8 bytes wide, C rows are 16 bytes (two 64-bit halves)
    localparam logic [8:0] A_LIM = 9'(DIM * 8);
    localparam logic [8:0] C_LIM = 9'(DIM * 16);

    logic [7:0] off;

    // Region lookup and per-region row/error extraction
    always_comb begin
        region_o = addr_i[15:8];
        off      = addr_i[7:0];
        row_o    = '0;
        c_half_o = 1'b0;
        start_o  = 1'b0;
        err_o    = 1'b0;
        case (region_o)
            REG_A: begin
                row_o = addr_i[3 +: ROWW];
                err_o = ({1'b0, off} >= A_LIM);
            end
            REG_B: begin
                err_o = !we_i;
            end
            REG_C: begin
                row_o    = addr_i[4 +: ROWW];
                c_half_o = addr_i[3];
                err_o    = ({1'b0, off} >= C_LIM);
            end
            REG_START: begin
                err_o   = !we_i;
                start_o = we_i;
            end
            default: begin
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/tpu_mult_ctrl.sv
// TPU datapath controller: decodes single-word host requests into
// memA/memB/array strobes and sequences a fixed-length matrix multiply
// while holding off host traffic.
// Optional build macro TPU_CTRL_PERF_EN adds a saturating count of
// completed multiplies on perf_mult_cnt; without it the port is 0.
module tpu_mult_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter  int DIM   = 8,
    parameter  int ADDRW = 16,
    localparam int ROWW  = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [ADDRW-1:0] req_addr,
    output logic             req_ready,
    output logic             rd_valid,
    output logic             err,
    output logic             a_en,
    output logic             a_wr_en,
    output logic [ROWW-1:0]  a_row,
    output logic             b_en,
    output logic             sa_en,
    output logic             sa_wr_en,
    output logic [ROWW-1:0]  sa_row,
    output logic             c_half,
    output logic             busy,
    output logic             done,
    output logic [15:0]      perf_mult_cnt
);

    localparam int MUL_CYCLES = mul_cycles(DIM);
    localparam int CNTW       = ($clog2(MUL_CYCLES) > 5) ? $clog2(MUL_CYCLES) : 5;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MUL_CYCLES - 1);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    // Request fields captured at acceptance; strobes only look at these
    logic            we_q;
    logic [7:0]      region_q;
    logic [ROWW-1:0] row_q;
    logic            c_half_q;

    logic [7:0]      dec_region;
    logic [ROWW-1:0] dec_row;
    logic            dec_c_half;
    logic            dec_start;
    logic            dec_err;
    logic            accept;

    tpu_addr_decode #(
        .DIM   (DIM),
        .ADDRW (ADDRW),
        .ROWW  (ROWW)
    ) u_dec (
        .we_i     (req_we),
        .addr_i   (req_addr),
        .region_o (dec_region),
        .row_o    (dec_row),
        .c_half_o (dec_c_half),
        .start_o  (dec_start),
        .err_o    (dec_err)
    );

    assign accept = req_valid && req_ready;

    // Control state: FSM state, multiply counter and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Capture the decoded request for use during the ACCESS cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q     <= req_we;
            region_q <= dec_region;
            row_q    <= dec_row;
            c_half_q <= dec_c_half;
        end
    end

    // Next-state logic; bad requests are swallowed in IDLE with an err pulse
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_err) begin
                        err_d = 1'b1;
                    end else if (dec_start) begin
                        state_d = MULTIPLY;
                        cnt_d   = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = IDLE;
            end
            MULTIPLY: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state and captured request only
    always_comb begin
        req_ready = (state_q == IDLE);
        err       = err_q;
        rd_valid  = 1'b0;
        a_en      = 1'b0;
        a_wr_en   = 1'b0;
        a_row     = '0;
        b_en      = 1'b0;
        sa_en     = 1'b0;
        sa_wr_en  = 1'b0;
        sa_row    = '0;
        c_half    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ACCESS: begin
                case (region_q)
                    REG_A: begin
                        a_en     = 1'b1;
                        a_wr_en  = we_q;
                        a_row    = row_q;
                        rd_valid = !we_q;
                    end
                    REG_B: begin
                        b_en = we_q;
                    end
                    REG_C: begin
                        sa_wr_en = we_q;
                        sa_row   = row_q;
                        c_half   = c_half_q;
                        rd_valid = !we_q;
                    end
                    default: begin
                    end
                endcase
            end
            MULTIPLY: begin
                busy  = 1'b1;
                a_en  = 1'b1;
                b_en  = 1'b1;
                sa_en = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

`ifdef TPU_CTRL_PERF_EN
    logic [15:0] perf_q;

    // Saturating count of completed multiplies
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (done && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign perf_mult_cnt = perf_q;
`else
    assign perf_mult_cnt = '0;
`endif

endmodule

// File: doc/tpu_mult_ctrl.md
Name: tpu_mult_ctrl

Overview:
- Sequencing and arbitration controller for the TPU datapath: memA, memB and the systolic array.
- Accepts single-word host read/write requests on the DATAW bus and decodes them into memory/array strobes.
- A write to the START address launches a matrix multiply. During the multiply the controller runs memA/memB/array in lockstep for a fixed cycle count and stalls host traffic until it completes.

Parameters:
- DIM, 8, systolic array dimension (rows = cols).
- ADDRW, 16, host address width.
- ROWW, $clog2(DIM), row-select width (derived, localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  host request present
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDRW  host byte address
- req_ready  out  1  request accepted this cycle (valid && ready)
- rd_valid  out  1  read data on datapath output is valid this cycle
- err  out  1  1-cycle pulse: unmapped address or illegal access
- a_en  out  1  memA enable
- a_wr_en  out  1  memA row write
- a_row  out  ROWW  memA row select
- b_en  out  1  memB enable (shift-in on write, shift-out in multiply)
- sa_en  out  1  systolic array compute enable
- sa_wr_en  out  1  array C-row write
- sa_row  out  ROWW  array C row select
- c_half  out  1  0 = low 64 bits of C row, 1 = high 64 bits
- busy  out  1  multiply in progress
- done  out  1  1-cycle pulse when multiply completes
- perf_mult_cnt  out  16  completed-multiply count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE; all outputs 0 except req_ready = 1. Reset mid-multiply aborts the multiply immediately: no done pulse and no further enables.
- Address map, by req_addr[15:8]:
  - 0x01: A. Row = addr[3 +: ROWW]; addr[7:0] >= DIM*8 -> err.
  - 0x02: B. Write only; offset ignored; a read -> err.
  - 0x03: C. Row = addr[4 +: ROWW]; c_half = addr[3]; addr[7:0] >= DIM*16 -> err.
  - 0x04: START. Write only; a read -> err.
  - Any other region -> err.
- States: IDLE, ACCESS, MULTIPLY, DONE.
- IDLE:
  - req_ready = 1.
  - Accepted request: latch we/addr and go to ACCESS.
  - Accepted START write: go to MULTIPLY directly.
  - Erroneous request: accepted, err pulses in the following cycle, no strobes, stays IDLE.
- ACCESS (exactly 1 cycle, req_ready = 0):
  - A write: a_en = a_wr_en = 1, a_row set.
  - A read: a_en = 1, rd_valid = 1.
  - B write: b_en = 1.
  - C write: sa_wr_en = 1, sa_row/c_half set.
  - C read: rd_valid = 1, sa_row/c_half set; array output is combinational by row.
  - Next state: IDLE. Throughput is 1 request per 2 cycles.
- MULTIPLY:
  - busy = 1; a_en = b_en = sa_en = 1 for exactly MUL_CYCLES = 3*DIM-2 cycles (22 at DIM=8).
  - 5-bit-minimum cycle counter runs 0..MUL_CYCLES-1; on the last count go to DONE.
  - req_ready = 0 throughout; host requests are held, not dropped.
- DONE (1 cycle): done = 1, busy = 0, no enables. Next state: IDLE.
- Outputs are decoded from registered state and latched request only; no combinational path from req_* to strobes.
- req_ready is combinational from state only.
- All strobes are mutually exclusive except the a_en/b_en/sa_en triple in MULTIPLY.

Optional Feature:
- Macro: TPU_CTRL_PERF_EN.
- Defined: perf_mult_cnt increments by 1 on each done pulse, saturates at 0xFFFF, and is cleared by rst.
- Undefined: perf_mult_cnt is tied to 0 and no counter register is synthesized.

Decomposition:
- Package tpu_ctrl_pkg holds:
  - state_t enum (IDLE, ACCESS, MULTIPLY, DONE);
  - region constants REG_A = 8'h01, REG_B = 8'h02, REG_C = 8'h03, REG_START = 8'h04;
  - function mul_cycles(dim) returning 3*dim-2.
- One sub-module is natural: tpu_addr_decode, purely combinational. It maps addr/we to region, row, c_half and err.

Test Plan:
- Reset, then write 0x0118 -> next cycle a_en = a_wr_en = 1, a_row = 3; req_ready low for 1 cycle, then high.
- Read 0x0338 -> ACCESS cycle rd_valid = 1, sa_row = 3, c_half = 1; no write strobes.
- Write 0x0400 -> busy high; a_en/b_en/sa_en high for exactly 22 cycles; done pulses 1 cycle; then IDLE.
- req_valid held during MULTIPLY -> req_ready stays 0 until IDLE, then the request is accepted; it is not lost.
- Read 0x0200, write 0x0140, write 0x0900 -> err pulses once each; no strobes.
- rst asserted at multiply cycle 10 -> next cycle all enables 0, no done pulse. With TPU_CTRL_PERF_EN, two full multiplies give perf_mult_cnt = 2.
